// File: rtl/int_pkg.sv
// Shared definitions for the PicoBlaze interrupt responder: FSM states and
// I/O register offsets relative to the block's port base.
package int_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_e;

   localparam logic [7:0] OFS_STATUS = 8'd0;
   localparam logic [7:0] OFS_MASK   = 8'd1;
   localparam logic [7:0] OFS_OVR    = 8'd2;

endpackage

// File: rtl/int_ovr_counter.sv
// Saturating per-source overrun counter; a clear beats a simultaneous increment.
module int_ovr_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/int_ack_handler.sv
// PicoBlaze interrupt responder: latches tick pulses, presents one held interrupt
// at a time in priority order, retires it on ack or timeout, and exposes registers.
module int_ack_handler
   import int_pkg::*;
#(
   parameter int                 NUM_SRC     = 4,
   parameter logic [7:0]         PORT_BASE   = 8'h10,
   parameter int                 OVR_WIDTH   = 4,
   parameter int                 ACK_TIMEOUT = 1024,
   parameter logic [NUM_SRC-1:0] MASK_RESET  = '1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] tick,
   output logic               interrupt,
   input  logic               interrupt_ack,
   input  logic [7:0]         port_id,
   input  logic [7:0]         out_port,
   input  logic               write_strobe,
   output logic [7:0]         in_port
);

   localparam int ID_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   localparam logic [7:0] ADDR_STATUS = PORT_BASE + OFS_STATUS;
   localparam logic [7:0] ADDR_MASK   = PORT_BASE + OFS_MASK;
   localparam logic [7:0] ADDR_OVR    = PORT_BASE + OFS_OVR;

   state_e              state_q, state_d;
   logic [NUM_SRC-1:0]  pending_q, pending_d;
   logic [NUM_SRC-1:0]  mask_q, mask_d;
   logic                tmo_q, tmo_d;
   logic [ID_W-1:0]     active_id_q, active_id_d;
   logic [CNT_W-1:0]    wait_q, wait_d;
   logic                interrupt_q;
   logic [7:0]          in_port_q, in_port_d;

   logic                wr_status, wr_mask, wr_ovr;
   logic                sel_valid, take;
   logic [ID_W-1:0]     sel_id;
   logic [NUM_SRC-1:0]  clr_sel, tick_en, ovr_inc;
   logic [OVR_WIDTH-1:0] ovr_cnt [NUM_SRC];
   logic [OVR_WIDTH-1:0] ovr_sel;
   logic                unused_out_port;

   // Only the low NUM_SRC data bits carry meaning (mask writes).
   assign unused_out_port = ^out_port;

   assign wr_status = write_strobe && (port_id == ADDR_STATUS);
   assign wr_mask   = write_strobe && (port_id == ADDR_MASK);
   assign wr_ovr    = write_strobe && (port_id == ADDR_OVR);

   // Lowest pending index wins.
   always_comb begin
      sel_valid = 1'b0;
      sel_id    = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            sel_valid = 1'b1;
            sel_id    = ID_W'(i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      active_id_d = active_id_q;
      wait_d      = '0;
      tmo_d       = tmo_q;
      take        = 1'b0;
      if (wr_status) begin
         tmo_d = 1'b0;
      end
      case (state_q)
         ST_IDLE: begin
            if (sel_valid) begin
               take        = 1'b1;
               active_id_d = sel_id;
               state_d     = ST_ASSERT;
            end
         end
         ST_ASSERT: begin
            // Ack is checked first so a same-cycle ack never flags a timeout.
            if (interrupt_ack) begin
               state_d = ST_HOLDOFF;
            end else if (wait_q == WAIT_LAST) begin
               state_d = ST_HOLDOFF;
               tmo_d   = 1'b1;
            end else begin
               wait_d = wait_q + CNT_W'(1);
            end
         end
         ST_HOLDOFF: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         clr_sel[i] = take && (sel_id == ID_W'(i));
      end
      tick_en   = tick & mask_q;
      // A tick landing on the bit being taken re-arms it without counting an overrun.
      ovr_inc   = tick_en & pending_q & ~clr_sel;
      pending_d = (pending_q & ~clr_sel) | tick_en;
      mask_d    = mask_q;
      if (wr_mask) begin
         mask_d    = out_port[NUM_SRC-1:0];
         pending_d = pending_d & ~(mask_q & ~out_port[NUM_SRC-1:0]);
      end
   end

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ovr
      int_ovr_counter #(
         .WIDTH (OVR_WIDTH)
      ) u_ovr (
         .clk   (clk),
         .reset (reset),
         .inc_i (ovr_inc[gi]),
         .clr_i (wr_ovr),
         .cnt_o (ovr_cnt[gi])
      );
   end

   always_comb begin
      ovr_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (active_id_q == ID_W'(i)) begin
            ovr_sel = ovr_cnt[i];
         end
      end
   end

   always_comb begin
      in_port_d = '0;
      if (port_id == ADDR_STATUS) begin
         in_port_d[7]        = (state_q != ST_IDLE);
         in_port_d[6]        = tmo_q;
         in_port_d[ID_W-1:0] = active_id_q;
      end else if (port_id == ADDR_MASK) begin
         in_port_d[NUM_SRC-1:0] = mask_q;
      end else if (port_id == ADDR_OVR) begin
         in_port_d[OVR_WIDTH-1:0] = ovr_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pending_q   <= '0;
         mask_q      <= MASK_RESET;
         tmo_q       <= 1'b0;
         active_id_q <= '0;
         wait_q      <= '0;
         interrupt_q <= 1'b0;
         in_port_q   <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         mask_q      <= mask_d;
         tmo_q       <= tmo_d;
         active_id_q <= active_id_d;
         wait_q      <= wait_d;
         interrupt_q <= (state_d == ST_ASSERT);
         in_port_q   <= in_port_d;
      end
   end

   assign interrupt = interrupt_q;
   assign in_port   = in_port_q;

endmodule

// File: tb/tb_int_ack_handler.sv
// Directed scenarios plus randomized traffic for int_ack_handler, checked every
// cycle against a behavioural model of pending/overrun/mask/service rules.
module tb_int_ack_handler;

   localparam int         NUM     = 4;
   localparam int         TMO     = 16;
   localparam logic [7:0] BASE    = 8'h10;
   localparam int         OVR_MAX = 15;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] tick;
   logic       interrupt;
   logic       interrupt_ack;
   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       write_strobe;
   logic [7:0] in_port;

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model state
   bit [3:0] m_pend;
   int       m_ovr [NUM];
   bit [3:0] m_mask;
   bit       m_tmo;
   int       m_active;
   bit       m_asserting;
   bit       m_gap;
   int       m_age;
   bit       m_int;
   bit [7:0] m_inport;

   logic       obs_int;
   logic [7:0] obs_in;

   always #5 clk = ~clk;

   int_ack_handler #(
      .NUM_SRC     (NUM),
      .PORT_BASE   (BASE),
      .OVR_WIDTH   (4),
      .ACK_TIMEOUT (TMO),
      .MASK_RESET  (4'hF)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .tick          (tick),
      .interrupt     (interrupt),
      .interrupt_ack (interrupt_ack),
      .port_id       (port_id),
      .out_port      (out_port),
      .write_strobe  (write_strobe),
      .in_port       (in_port)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend      = '0;
      for (int i = 0; i < NUM; i++) m_ovr[i] = 0;
      m_mask      = 4'hF;
      m_tmo       = 1'b0;
      m_active    = 0;
      m_asserting = 1'b0;
      m_gap       = 1'b0;
      m_age       = 0;
      m_int       = 1'b0;
      m_inport    = '0;
   endtask

   task automatic model_step(input logic [3:0] t, input logic a, input logic [7:0] pid,
                             input logic [7:0] od, input logic ws, input logic r);
      int taken;
      bit timeout;
      bit busy;
      if (r) begin
         model_reset();
         return;
      end
      busy = m_asserting || m_gap;
      if (pid == BASE)          m_inport = {busy, m_tmo, 3'b000, 3'(m_active)};
      else if (pid == BASE + 1) m_inport = {4'b0000, m_mask};
      else if (pid == BASE + 2) m_inport = 8'(m_ovr[m_active]);
      else                      m_inport = 8'h00;

      taken = -1;
      if (!busy) begin
         for (int i = NUM - 1; i >= 0; i--) if (m_pend[i]) taken = i;
      end

      timeout = 1'b0;
      if (m_asserting) begin
         if (a) begin
            m_asserting = 1'b0;
            m_gap       = 1'b1;
            $display("[TB] irq src=%0d acked after %0d cycles", m_active, m_age + 1);
         end else if (m_age == TMO - 1) begin
            m_asserting = 1'b0;
            m_gap       = 1'b1;
            timeout     = 1'b1;
            $display("[TB] irq src=%0d timed out", m_active);
         end else begin
            m_age++;
         end
      end else if (m_gap) begin
         m_gap = 1'b0;
      end else if (taken >= 0) begin
         m_asserting = 1'b1;
         m_age       = 0;
         m_active    = taken;
      end

      for (int i = 0; i < NUM; i++) begin
         if (t[i] && m_mask[i]) begin
            if (m_pend[i] && i != taken) begin
               if (m_ovr[i] < OVR_MAX) m_ovr[i]++;
            end else begin
               m_pend[i] = 1'b1;
            end
         end else if (i == taken) begin
            m_pend[i] = 1'b0;
         end
      end

      if (ws && pid == BASE + 2) begin
         for (int i = 0; i < NUM; i++) m_ovr[i] = 0;
      end
      if (ws && pid == BASE + 1) begin
         for (int i = 0; i < NUM; i++) if (m_mask[i] && !od[i]) m_pend[i] = 1'b0;
         m_mask = od[3:0];
      end
      if (ws && pid == BASE) m_tmo = 1'b0;
      if (timeout) m_tmo = 1'b1;
      m_int = m_asserting;
   endtask

   task automatic cycle(input logic [3:0] t, input logic a, input logic [7:0] pid,
                        input logic [7:0] od, input logic ws, input logic r);
      tick          = t;
      interrupt_ack = a;
      port_id       = pid;
      out_port      = od;
      write_strobe  = ws;
      reset         = r;
      @(negedge clk);
      obs_int = interrupt;
      obs_in  = in_port;
      check_eq("interrupt", {31'b0, interrupt}, {31'b0, m_int});
      check_eq("in_port", {24'b0, in_port}, {24'b0, m_inport});
      @(posedge clk);
      model_step(t, a, pid, od, ws, r);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(4'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic ack();
      cycle(4'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic wr(input logic [7:0] ofs, input logic [7:0] data);
      cycle(4'b0, 1'b0, BASE + ofs, data, 1'b1, 1'b0);
   endtask

   task automatic rd_expect(input logic [7:0] ofs, input logic [7:0] exp, input string tag);
      cycle(4'b0, 1'b0, BASE + ofs, 8'h00, 1'b0, 1'b0);
      cycle(4'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      check_eq(tag, {24'b0, obs_in}, {24'b0, exp});
   endtask

   task automatic wait_int_high(input string tag);
      for (int k = 0; k < 40; k++) begin
         idle(1);
         if (obs_int === 1'b1) break;
      end
      check_eq(tag, {31'b0, obs_int}, 32'd1);
   endtask

   initial begin
      int n;
      logic [3:0] t;
      logic [7:0] pid;
      logic [7:0] pid_tab [6];

      reset = 1'b1; tick = '0; interrupt_ack = 1'b0;
      port_id = '0; out_port = '0; write_strobe = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();
      #1;

      // reset state
      idle(1);
      check_eq("rst_int", {31'b0, obs_int}, 32'd0);
      check_eq("rst_inport", {24'b0, obs_in}, 32'd0);
      rd_expect(8'd1, 8'h0F, "rst_mask");

      // 1: latency, holdoff gap, clear/set race
      $display("[TB] test 1 latency and holdoff");
      cycle(4'b0001, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);            // T
      check_eq("t1_T", {31'b0, obs_int}, 32'd0);
      cycle(4'b0001, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);            // T+1, race tick
      check_eq("t1_T1", {31'b0, obs_int}, 32'd0);
      for (int k = 2; k <= 5; k++) begin
         idle(1);
         check_eq("t1_high", {31'b0, obs_int}, 32'd1);
      end
      ack();                                                      // T+6
      check_eq("t1_T6", {31'b0, obs_int}, 32'd1);
      idle(1);
      check_eq("t1_T7", {31'b0, obs_int}, 32'd0);
      idle(1);
      check_eq("t1_T8", {31'b0, obs_int}, 32'd0);
      idle(1);
      check_eq("t1_T9", {31'b0, obs_int}, 32'd1);
      rd_expect(8'd2, 8'h00, "t1_race_ovr");
      ack();
      idle(3);

      // 2: simultaneous ticks served by priority
      $display("[TB] test 2 priority");
      cycle(4'b0101, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      idle(1);
      rd_expect(8'd0, 8'h80, "t2_src0");
      ack();
      wait_int_high("t2_wait");
      rd_expect(8'd0, 8'h82, "t2_src2");
      ack();
      idle(3);

      // 3: overrun during service
      $display("[TB] test 3 overrun");
      cycle(4'b0010, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      wait_int_high("t3_wait");
      cycle(4'b0010, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      idle(1);
      cycle(4'b0010, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      rd_expect(8'd2, 8'h01, "t3_ovr1");
      wr(8'd2, 8'h00);
      rd_expect(8'd2, 8'h00, "t3_ovr0");
      ack();
      wait_int_high("t3_again");
      rd_expect(8'd0, 8'h81, "t3_status");
      ack();
      idle(3);

      // 4: timeout
      $display("[TB] test 4 timeout");
      cycle(4'b0001, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      wait_int_high("t4_wait");
      n = 1;
      for (int k = 0; k < 40; k++) begin
         idle(1);
         if (obs_int !== 1'b1) break;
         n++;
      end
      check_eq("t4_len", n, TMO);
      rd_expect(8'd0, 8'h40, "t4_tmo_set");
      wr(8'd0, 8'h00);
      rd_expect(8'd0, 8'h00, "t4_tmo_clr");

      // 5: masking
      $display("[TB] test 5 mask");
      wr(8'd1, 8'h0E);
      cycle(4'b0001, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      idle(4);
      check_eq("t5_masked", {31'b0, obs_int}, 32'd0);
      cycle(4'b0010, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      wait_int_high("t5_src1");
      ack();
      wr(8'd1, 8'h0F);
      idle(6);
      check_eq("t5_nopend", {31'b0, obs_int}, 32'd0);
      rd_expect(8'd1, 8'h0F, "t5_mask");

      // 6: reset during ASSERT
      $display("[TB] test 6 reset in service");
      cycle(4'b0001, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      wait_int_high("t6_wait");
      cycle(4'b0001, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      cycle(4'b0001, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      rd_expect(8'd2, 8'h01, "t6_ovr_pre");
      cycle(4'b0000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      idle(1);
      check_eq("t6_int", {31'b0, obs_int}, 32'd0);
      rd_expect(8'd1, 8'h0F, "t6_mask");
      rd_expect(8'd0, 8'h00, "t6_status");
      rd_expect(8'd2, 8'h00, "t6_ovr");

      // randomized traffic
      $display("[TB] random phase");
      pid_tab[0] = BASE; pid_tab[1] = BASE + 8'd1; pid_tab[2] = BASE + 8'd2;
      pid_tab[3] = BASE + 8'd3; pid_tab[4] = 8'h00; pid_tab[5] = 8'h55;
      for (int k = 0; k < 3000; k++) begin
         for (int b = 0; b < NUM; b++) t[b] = ($urandom_range(0, 5) == 0);
         pid = pid_tab[$urandom_range(0, 5)];
         cycle(t, ($urandom_range(0, 5) == 0), pid, 8'($urandom),
               ($urandom_range(0, 11) == 0), ($urandom_range(0, 399) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
